btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Input stage between the board push-buttons and the player-position logic.
- Synchronises the raw left, right and fire buttons to i_Clk and debounces each one.
- Emits one-cycle press pulses, plus frame-latched movement levels that only change on i_fTick.
- The movement levels (o_Btn_Left, o_Btn_Right) drive the player-position block's button inputs directly and stay stable for a whole frame.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the synchronised input must hold a new level before it is accepted (10 ms at 50 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width.
- ACTIVE_LOW, 0: when 1, the raw inputs are inverted before the synchronisers.

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  reset, asynchronous, active-high
- i_Btn_Left_Raw  input  1  raw left button
- i_Btn_Right_Raw  input  1  raw right button
- i_Btn_Fire_Raw  input  1  raw fire button
- i_fTick  input  1  one-cycle frame tick (start of vertical blank)
- o_Btn_Left  output  1  frame-latched left-move level
- o_Btn_Right  output  1  frame-latched right-move level
- o_Btn_Fire  output  1  frame-latched fire level
- o_Left_Press  output  1  one-cycle pulse on debounced left press
- o_Right_Press  output  1  one-cycle pulse on debounced right press
- o_Fire_Press  output  1  one-cycle pulse on debounced fire press

Behaviour:
- Reset: all outputs 0; synchroniser flops 0 (post-polarity); every FSM in IDLE; counters 0.
- Reset mid-debounce aborts the debounce immediately and returns to the reset state.
- Synchroniser: per button, optional inversion, then a 2-flop synchroniser producing s. No logic sits between the two flops.
- Per-button FSM (in the debounce sub-module); N = DEBOUNCE_CYCLES.
  - IDLE: if s=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT:
    - s=0: go to IDLE (bounce rejected).
    - s=1 and cnt==N-1: go to PRESSED and assert press pulse for exactly one cycle.
    - otherwise: cnt+1.
  - PRESSED: if s=0, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT:
    - s=1: go to PRESSED (bounce rejected, no pulse).
    - s=0 and cnt==N-1: go to IDLE.
    - otherwise: cnt+1.
  - Debounced level lvl = (state==PRESSED or state==RELEASE_WAIT).
- Latency:
  - Raw rise held steady from before edge k makes lvl and the press pulse visible after edge k+N+2 (2 synchroniser edges + 1 IDLE exit + N counted edges).
  - Release has the same N+2 latency, with no pulse.
- Counter: CNT_W bits, never exceeds N-1, no wrap. It only counts in the *_WAIT states.
- Frame latch, registered on the edge where i_fTick=1:
  - o_Btn_Left <= lvlL & ~lvlR
  - o_Btn_Right <= lvlR & ~lvlL
  - o_Btn_Fire <= lvlF
  - Both directions pressed: both movement outputs 0 (cancel, no priority).
  - Outputs hold between ticks, regardless of lvl changes.
- Press pulses are not frame-latched.
  - A press occurring while i_fTick=1 pulses normally.
  - The frame latch on that same edge samples the pre-edge lvl (still 0).
- i_fTick asserted for several consecutive cycles: the latch re-samples every such cycle; no error.
- Buttons are fully independent; simultaneous events on different buttons are processed in parallel.

Decomposition:
- Shared package btn_pkg holds:
  - the FSM state encoding localparams: ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_PRESSED=2'd2, ST_RELEASE_WAIT=2'd3;
  - PLAY_W=240 and PLAYER_W=24, for reuse by the position stage.
- Sub-module btn_debounce: synchroniser + FSM + counter for one button.
  - Parameters: DEBOUNCE_CYCLES, CNT_W, ACTIVE_LOW.
  - Outputs: lvl and press pulse.
  - Instantiated three times.
- The top level holds only the frame latch and the direction-cancel logic.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset asserted mid-PRESS_WAIT (left held 3 cycles) -> all outputs 0 immediately; after release of reset with left still high, o_Left_Press fires 6 cycles later.
- Left raw 0->1 held clean before edge 0 -> o_Left_Press high only in the cycle after edge 6; next i_fTick sets o_Btn_Left=1, o_Btn_Right=0.
- Left raw toggles 1,0,1,0 with 2-cycle pulses (bounce shorter than N) -> no press pulse; o_Btn_Left stays 0 across 3 ticks.
- Left held, then released with a 2-cycle release glitch -> lvl stays 1, no second pulse on re-settle; clean release drops o_Btn_Left at the first i_fTick after the N+2-cycle release latency.
- Left and right both debounced high, then i_fTick -> o_Btn_Left=0, o_Btn_Right=0; release right, next tick -> o_Btn_Left=1.
- ACTIVE_LOW=1, raw fire driven 1->0 -> o_Fire_Press pulse 6 cycles later; o_Btn_Fire=1 after the next i_fTick and unchanged until the following tick.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button input stage and the player-position stage.
// Holds the debounce FSM encoding plus playfield geometry constants.
package btn_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE         = ST_IDLE,
    S_PRESS_WAIT   = ST_PRESS_WAIT,
    S_PRESSED      = ST_PRESSED,
    S_RELEASE_WAIT = ST_RELEASE_WAIT
  } btn_state_t;

  localparam int PLAY_W   = 240;
  localparam int PLAYER_W = 24;

  // The debounced level is high from the accepted press until the release is accepted.
  function automatic logic is_level_high(input btn_state_t st);
    return (st == S_PRESSED) || (st == S_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: optional polarity inversion, 2-flop synchroniser, and a
// press/release debounce FSM that accepts a new level after it holds for N cycles.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Btn_Raw,
  output logic o_Lvl,
  output logic o_Press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       btn_pol;
  logic       sync_meta;
  logic       sync_s;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       press_q, press_d;

  assign btn_pol = ACTIVE_LOW ? ~i_Btn_Raw : i_Btn_Raw;

  // NOTE: non-blocking assignments make sync_s take the old sync_meta; blocking ones
  // would collapse the two flops into one and defeat the synchroniser.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= btn_pol;
      sync_s    <= sync_meta;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sync_s) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!sync_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!sync_s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        // A return to 1 during the wait is a bounce: back to PRESSED with no new pulse.
        if (sync_s) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_Lvl   = is_level_high(state_q);
  assign o_Press = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button input stage: three debounced buttons, one-cycle press pulses, and
// movement/fire levels latched once per frame on i_fTick.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Btn_Left_Raw,
  input  logic i_Btn_Right_Raw,
  input  logic i_Btn_Fire_Raw,
  input  logic i_fTick,
  output logic o_Btn_Left,
  output logic o_Btn_Right,
  output logic o_Btn_Fire,
  output logic o_Left_Press,
  output logic o_Right_Press,
  output logic o_Fire_Press
);

  logic lvl_left;
  logic lvl_right;
  logic lvl_fire;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_left (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Btn_Raw(i_Btn_Left_Raw),
    .o_Lvl    (lvl_left),
    .o_Press  (o_Left_Press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_right (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Btn_Raw(i_Btn_Right_Raw),
    .o_Lvl    (lvl_right),
    .o_Press  (o_Right_Press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_fire (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Btn_Raw(i_Btn_Fire_Raw),
    .o_Lvl    (lvl_fire),
    .o_Press  (o_Fire_Press)
  );

  // Opposing directions cancel each other with no priority; levels hold between ticks.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Btn_Left  <= 1'b0;
      o_Btn_Right <= 1'b0;
      o_Btn_Fire  <= 1'b0;
    end else if (i_fTick) begin
      o_Btn_Left  <= lvl_left & ~lvl_right;
      o_Btn_Right <= lvl_right & ~lvl_left;
      o_Btn_Fire  <= lvl_fire;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: a run-length reference model checked every cycle
// against an active-high and an active-low instance, plus directed literal checks.
module tb_btn_conditioner;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ftick = 1'b0;
  logic [2:0] raw0 = 3'b000;  // [0]=left [1]=right [2]=fire, active-high instance
  logic [2:0] raw1 = 3'b111;  // same ordering, active-low instance (idle high)

  logic o0_btn_left, o0_btn_right, o0_btn_fire, o0_left_press, o0_right_press, o0_fire_press;
  logic o1_btn_left, o1_btn_right, o1_btn_fire, o1_left_press, o1_right_press, o1_fire_press;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(2), .ACTIVE_LOW(1'b0)) dut0 (
    .i_Clk(clk), .i_Rst(rst),
    .i_Btn_Left_Raw(raw0[0]), .i_Btn_Right_Raw(raw0[1]), .i_Btn_Fire_Raw(raw0[2]),
    .i_fTick(ftick),
    .o_Btn_Left(o0_btn_left), .o_Btn_Right(o0_btn_right), .o_Btn_Fire(o0_btn_fire),
    .o_Left_Press(o0_left_press), .o_Right_Press(o0_right_press), .o_Fire_Press(o0_fire_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(2), .ACTIVE_LOW(1'b1)) dut1 (
    .i_Clk(clk), .i_Rst(rst),
    .i_Btn_Left_Raw(raw1[0]), .i_Btn_Right_Raw(raw1[1]), .i_Btn_Fire_Raw(raw1[2]),
    .i_fTick(ftick),
    .o_Btn_Left(o1_btn_left), .o_Btn_Right(o1_btn_right), .o_Btn_Fire(o1_btn_fire),
    .o_Left_Press(o1_left_press), .o_Right_Press(o1_right_press), .o_Fire_Press(o1_fire_press)
  );

  // Reference model: the synchronised input is the polarity-corrected raw input
  // delayed two edges; the debounced level flips once the synchronised input has
  // disagreed with it for N+1 consecutive edges, and a flip to 1 is a press pulse.
  bit m_sp1   [2][3];
  bit m_sp2   [2][3];
  bit m_lvl   [2][3];
  bit m_pulse [2][3];
  int m_run   [2][3];
  bit m_l [2];
  bit m_r [2];
  bit m_f [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_l[d] = 1'b0; m_r[d] = 1'b0; m_f[d] = 1'b0;
      for (int b = 0; b < 3; b++) begin
        m_sp1[d][b] = 1'b0; m_sp2[d][b] = 1'b0; m_lvl[d][b] = 1'b0;
        m_pulse[d][b] = 1'b0; m_run[d][b] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (ftick) begin
        m_l[d] = m_lvl[d][0] & ~m_lvl[d][1];
        m_r[d] = m_lvl[d][1] & ~m_lvl[d][0];
        m_f[d] = m_lvl[d][2];
      end
      for (int b = 0; b < 3; b++) begin
        m_pulse[d][b] = 1'b0;
        if (m_sp2[d][b] != m_lvl[d][b]) m_run[d][b] = m_run[d][b] + 1;
        else                            m_run[d][b] = 0;
        if (m_run[d][b] == N + 1) begin
          m_lvl[d][b]   = m_sp2[d][b];
          m_pulse[d][b] = m_sp2[d][b];
          m_run[d][b]   = 0;
        end
        m_sp2[d][b] = m_sp1[d][b];
        m_sp1[d][b] = (d == 0) ? raw0[b] : ~raw1[b];
      end
    end
  endtask

  function automatic logic [5:0] model_vec(input int d);
    return {m_l[d], m_r[d], m_f[d], m_pulse[d][0], m_pulse[d][1], m_pulse[d][2]};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {5'b0, act}, {5'b0, exp});
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    ftick = 1'b1;
    next_edge();
    ftick = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Outputs are {btn_left, btn_right, btn_fire, left_press, right_press, fire_press}.
  initial begin
    forever begin
      @(negedge clk);
      check("dut0 vs model", {o0_btn_left, o0_btn_right, o0_btn_fire,
                              o0_left_press, o0_right_press, o0_fire_press}, model_vec(0));
      check("dut1 vs model", {o1_btn_left, o1_btn_right, o1_btn_fire,
                              o1_left_press, o1_right_press, o1_fire_press}, model_vec(1));
    end
  end

  initial begin
    repeat (3) next_edge();
    check("reset dut0", {o0_btn_left, o0_btn_right, o0_btn_fire,
                         o0_left_press, o0_right_press, o0_fire_press}, 6'b000000);
    check("reset dut1", {o1_btn_left, o1_btn_right, o1_btn_fire,
                         o1_left_press, o1_right_press, o1_fire_press}, 6'b000000);
    rst = 1'b0;

    // Reset in the middle of PRESS_WAIT, then recover with left still held.
    raw0[0] = 1'b1;
    repeat (4) next_edge();
    check1("no press before mid reset", o0_left_press, 1'b0);
    #2 rst = 1'b1;
    #1 check("mid-debounce reset", {o0_btn_left, o0_btn_right, o0_btn_fire,
                                    o0_left_press, o0_right_press, o0_fire_press}, 6'b000000);
    next_edge();
    next_edge();
    rst = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      next_edge();
      check1($sformatf("post-reset left press after edge %0d", i), o0_left_press, i == 6);
    end

    // Clean press, with a frame tick on the very edge that accepts it.
    raw0[0] = 1'b0;
    repeat (12) next_edge();
    raw0[0] = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      ftick = (i == 6);
      next_edge();
      check1($sformatf("clean left press after edge %0d", i), o0_left_press, i == 6);
      if (i == 6) check1("tick on press edge samples old lvl", o0_btn_left, 1'b0);
    end
    ftick = 1'b0;
    pulse_tick();
    check1("left latched", o0_btn_left, 1'b1);
    check1("right not latched", o0_btn_right, 1'b0);

    // Short release glitch while held: level stays, no second pulse.
    raw0[0] = 1'b0;
    next_edge();
    next_edge();
    raw0[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      next_edge();
      check1($sformatf("no pulse after release glitch %0d", i), o0_left_press, 1'b0);
    end
    pulse_tick();
    check1("left held through glitch", o0_btn_left, 1'b1);

    // Clean release: a tick at edge 6 still sees the level, one at edge 7 does not.
    raw0[0] = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      ftick = (i == 6) || (i == 7);
      next_edge();
      if (i == 6) check1("tick inside release latency", o0_btn_left, 1'b1);
      if (i == 7) check1("tick after release latency", o0_btn_left, 1'b0);
    end
    ftick = 1'b0;

    // Bounces of two cycles each never reach N.
    for (int i = 0; i < 24; i++) begin
      raw0[0] = (i < 8) ? ((i % 4) < 2) : 1'b0;
      ftick   = ((i % 8) == 7);
      next_edge();
      check1($sformatf("bounce no pulse %0d", i), o0_left_press, 1'b0);
      check1($sformatf("bounce left stays 0 %0d", i), o0_btn_left, 1'b0);
    end
    ftick = 1'b0;

    // Both directions pressed cancel; fire pressed alongside them.
    raw0 = 3'b111;
    repeat (10) next_edge();
    pulse_tick();
    check1("both pressed: left 0", o0_btn_left, 1'b0);
    check1("both pressed: right 0", o0_btn_right, 1'b0);
    check1("fire latched with both", o0_btn_fire, 1'b1);
    raw0[1] = 1'b0;
    repeat (10) next_edge();
    check1("left holds until tick", o0_btn_left, 1'b0);
    pulse_tick();
    check1("right released: left 1", o0_btn_left, 1'b1);
    check1("right released: right 0", o0_btn_right, 1'b0);

    // fTick held high for many cycles re-samples every cycle.
    raw0 = 3'b000;
    ftick = 1'b1;
    repeat (10) next_edge();
    ftick = 1'b0;
    check1("long tick tracks release", o0_btn_left, 1'b0);
    check1("long tick tracks fire release", o0_btn_fire, 1'b0);

    // Active-low instance: fire driven 1->0.
    raw1[2] = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      next_edge();
      check1($sformatf("active-low fire press after edge %0d", i), o1_fire_press, i == 6);
    end
    pulse_tick();
    check1("active-low fire latched", o1_btn_fire, 1'b1);
    raw1[2] = 1'b1;
    repeat (10) next_edge();
    check1("active-low fire holds between ticks", o1_btn_fire, 1'b1);
    pulse_tick();
    check1("active-low fire cleared on tick", o1_btn_fire, 1'b0);

    repeat (3) next_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
